// File: rtl/rf_stream_reader_pkg.sv
// Shared definitions for the phit register-file access blocks: parameter
// defaults and the controller state encoding.
package rf_stream_reader_pkg;

    localparam int phit_size    = 32;
    localparam int dwidth_RFadd = 4;
    localparam int depth_RF     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rf_ctrl_state_t;

endpackage

// File: rtl/rf_stream_reader.sv
// Walks a wrapping range of register-file entries and streams each entry out
// through a single valid/ready output register with a last flag.
module rf_stream_reader
    import rf_stream_reader_pkg::*;
#(
    parameter int PHIT_W = phit_size,
    parameter int AW     = dwidth_RFadd,
    parameter int DEPTH  = depth_RF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW:0]       len,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     rf_rd_addr,
    input  logic [PHIT_W-1:0] rf_rd_data,
    output logic [PHIT_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   ONE       = (AW+1)'(1);

    rf_ctrl_state_t state, state_d;
    logic [AW-1:0]  ptr;
    logic [AW:0]    remaining;
    logic           free;
    logic           load;
    logic           accept;

    assign rf_rd_addr = ptr;
    assign free       = !m_tvalid || m_tready;
    assign accept     = m_tvalid && m_tready;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        unique case (state)
            ST_IDLE: begin
                if (start) state_d = (len == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                if (free) begin
                    load = 1'b1;
                    if (remaining == ONE) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Datapath: the beat is captured from the read port at the load edge, so a
    // same-edge write to that entry only shows up on a later read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
        end else begin
            if (state == ST_IDLE && start && len != '0) begin
                ptr       <= base_addr;
                remaining <= len;
            end

            if (load) begin
                m_tdata   <= rf_rd_data;
                m_tvalid  <= 1'b1;
                m_tlast   <= (remaining == ONE);
                ptr       <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
                remaining <= remaining - ONE;
            end else if (accept) begin
                m_tvalid  <= 1'b0;
                m_tlast   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_stream_reader.sv
// Scoreboard bench for rf_stream_reader: directed commands push expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_rf_stream_reader;
    import rf_stream_reader_pkg::*;

    localparam int PW    = phit_size;
    localparam int AW    = dwidth_RFadd;
    localparam int DEPTH = depth_RF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   cmd_len;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_rd_addr;
    logic [PW-1:0] rf_rd_data;
    logic [PW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;

    logic [PW-1:0] rf [DEPTH];

    typedef struct packed {
        logic [PW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    beat_t exp_beat;
    int    tests    = 0;
    int    fails    = 0;
    int    hs_count = 0;
    bit    pat [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    assign rf_rd_data = rf[rf_rd_addr];

    rf_stream_reader #(.PHIT_W(PW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (cmd_len),
        .busy       (busy),
        .done       (done),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected beat per handshake, and checks that a stalled
    // beat is still presented unchanged one cycle later.
    logic          stall_q;
    logic [PW-1:0] stall_data;
    logic          stall_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_data", m_tdata, stall_data);
                check("hold_last", 32'(m_tlast), 32'(stall_last));
            end
            if (m_tvalid && m_tready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", m_tdata, 32'hDEAD_BEEF);
                end else begin
                    exp_beat = sb.pop_front();
                    check("beat_data", m_tdata, exp_beat.data);
                    check("beat_last", 32'(m_tlast), 32'(exp_beat.last));
                end
            end
            stall_q    = m_tvalid && !m_tready;
            stall_data = m_tdata;
            stall_last = m_tlast;
        end
    end

    // Issues one command starting from posedge+1 and follows it to its done pulse.
    task automatic run_cmd(input int base, input int n, input bit bp,
                           input bit spur, input bit hazard, input bit chk_addr);
        int a;
        int first_v = -1;
        int done_c  = -1;
        int busy_c  = 0;
        int hs0;
        bit wr3;
        a = base;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{data: PW'(32'h11 * a), last: (i == n - 1)});
            a = (a == DEPTH - 1) ? 0 : a + 1;
        end
        hs0       = hs_count;
        base_addr = AW'(base);
        cmd_len   = (AW+1)'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 300 && done_c < 0; c++) begin
            m_tready = bp ? pat[(c - 1) % 6] : 1'b1;
            if (spur && c == 2) begin
                start     = 1'b1;
                base_addr = AW'(9);
                cmd_len   = (AW+1)'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (m_tvalid && first_v < 0) first_v = c;
            if (busy) busy_c++;
            if (done) done_c = c;
            if (chk_addr && c <= n) check("rd_addr", 32'(rf_rd_addr), 32'((base + c - 1) % DEPTH));
            wr3 = hazard && busy && rf_rd_addr == AW'(3);
            @(posedge clk);
            if (wr3) rf[3] <= 32'hAB;
            #1;
        end
        start    = 1'b0;
        m_tready = 1'b1;
        check("done_seen", 32'(done_c > 0), 32'd1);
        if (n > 0) check("first_beat_cycle", 32'(first_v), 32'd2);
        else       check("no_valid", 32'(first_v < 0), 32'd1);
        if (!bp) check("done_cycle", 32'(done_c), (n == 0) ? 32'd1 : 32'(n + 2));
        check("busy_cycles", 32'(busy_c), 32'(done_c));
        check("beat_count", 32'(hs_count - hs0), 32'(n));
        check("sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) rf[k] = PW'(32'h11 * k);
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        cmd_len   = '0;
        m_tready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(m_tvalid), 32'd0);
        check("rst_last", 32'(m_tlast), 32'd0);
        check("rst_data", m_tdata, 32'd0);
        check("rst_addr", 32'(rf_rd_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(2, 4, 1'b0, 1'b0, 1'b0, 1'b0);   // basic
        run_cmd(14, 4, 1'b0, 1'b0, 1'b0, 1'b1);  // wrap with address trace
        run_cmd(0, 6, 1'b1, 1'b0, 1'b0, 1'b0);   // backpressure
        run_cmd(7, 0, 1'b0, 1'b0, 1'b0, 1'b0);   // zero length
        run_cmd(5, 16, 1'b0, 1'b0, 1'b0, 1'b0);  // full depth, wraps once
        run_cmd(2, 4, 1'b0, 1'b1, 1'b0, 1'b0);   // start during READ ignored
        run_cmd(2, 3, 1'b0, 1'b0, 1'b1, 1'b0);   // same-edge write to entry 3
        check("hazard_write_landed", rf[3], 32'hAB);
        rf[3] = PW'(32'h33);

        // Reset while beat 2 of 8 is on the bus: only beat 1 handshakes.
        sb.push_back('{data: PW'(0), last: 1'b0});
        base_addr = '0;
        cmd_len   = (AW+1)'(8);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(m_tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(m_tvalid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_cmd(0, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rf_stream_reader.md
# rf_stream_reader

Read-side initiator for the phit register file. On a start command it walks a contiguous, wrapping range of register-file entries by driving the file's read address. Each entry's read data is captured into an output register and presented as a valid/ready phit stream with a last flag. It sits between the register file and any downstream phit consumer, such as a network egress or compute lane. Concurrent register-file writes continue through the file's own write port and are not touched by this block.

## Interface
- `PHIT_W`, default `phit_size`: stream and register-file data width.
- `AW`, default `dwidth_RFadd`: register-file address width.
- `DEPTH`, default `depth_RF`: number of entries; addresses run 0..DEPTH-1, with DEPTH ≤ 2^AW.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  AW  first entry to read; sampled with `start`.
- `len`  in  AW+1  entry count, 0..DEPTH; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a command.
- `rf_rd_addr`  out  AW  drives the register-file read address.
- `rf_rd_data`  in  PHIT_W  register-file read data, combinational from `rf_rd_addr`.
- `m_tdata`  out  PHIT_W  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tlast`  out  1  marks the final beat of a command.

## Operation
- **States:** IDLE, READ, DRAIN, DONE.
- **Internal registers:** `ptr` (AW bits) and `remaining` (AW+1 bits).
- **IDLE:**
  - `start`=1 with `len`≠0: load `ptr`=`base_addr` and `remaining`=`len`, go to READ.
  - `start`=1 with `len`=0: go to DONE.
  - Ignore `start` in every other state.
- **`rf_rd_addr`:** always equals `ptr`.
- **Output register free condition:** `free` = !`m_tvalid` || `m_tready`.
- **READ, when `free`:**
  - Capture `m_tdata`←`rf_rd_data` and set `m_tvalid`←1.
  - Set `m_tlast`←(`remaining`==1).
  - Advance `ptr`: set `ptr`←0 if `ptr`==DEPTH-1, else `ptr`+1.
  - Decrement `remaining`.
  - If `remaining` was 1, go to DRAIN.
- **READ, when not `free`:** hold all state; `m_tdata`, `m_tvalid` and `m_tlast` stay stable.
- **Plain accept:** a handshake (`m_tvalid`&&`m_tready`) with no new load clears `m_tvalid` and `m_tlast`.
- **DRAIN:** wait for the handshake on the last beat, clear `m_tvalid` and `m_tlast`, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE.
- **Snapshot semantics:** a beat carries the register-file contents at the edge where it is loaded. A write to the same address on that same edge is not visible in the beat.
- **Address wrap:** explicit at DEPTH-1; no reliance on power-of-two DEPTH.
- **`base_addr` ≥ DEPTH:** illegal. Behaviour is unspecified, and the bench must not drive it.

## Timing
- **Reset values:** `busy`, `done`, `m_tvalid` and `m_tlast` = 0; `m_tdata`, `rf_rd_addr`, `ptr` and `remaining` = 0; state IDLE.
- **Reset application:** asynchronous on `rst_n` falling, including mid-command. An in-flight beat is dropped without a handshake.
- **First-beat latency:** `start` sampled at edge E0 → READ during cycle 1 → first beat loaded at E1, visible with `m_tvalid`=1 in cycle 2.
- **Throughput:** one beat per cycle with `m_tready` held high; no bubbles between beats of a command.
- **`done` timing:** high in the cycle following the edge at which the last beat handshakes. For `len`=0, `done` is high in the cycle after E0 and no beat is emitted.
- **Back-to-back commands:** the earliest next `start` acceptance is the first IDLE cycle, one cycle after `done`.
- **`busy`:** high from the cycle after E0 through the `done` cycle inclusive.

## Structure
- The shared package holds `phit_size`, `dwidth_RFadd` and `depth_RF` as the parameter defaults.
- The shared package also holds the state enum typedef (IDLE/READ/DRAIN/DONE) for reuse by a future writer-side controller.
- No sub-module: the output register is a single stage inline with the FSM.

## Test plan
Common setup: DEPTH=16, AW=4; register-file entry k preloaded with value 0x11·k; the bench models the register file as a combinational read.
- **Basic stream:** `base_addr`=2, `len`=4, `m_tready`=1 → beats 0x22, 0x33, 0x44, 0x55 on consecutive cycles starting 2 cycles after `start`. `m_tlast` is set on 0x55 only, and `done` pulses one cycle after the last handshake.
- **Wrap:** `base_addr`=14, `len`=4 → beats 0xEE, 0xFF, 0x00, 0x11 with `rf_rd_addr` sequence 14, 15, 0, 1.
- **Backpressure:** `len`=6 with `m_tready` pattern 1,0,0,1,0,1,… → exactly 0x00 through 0x55 in order, no duplicates or drops. `m_tdata` and `m_tlast` are stable whenever `m_tvalid`&&!`m_tready`.
- **Edge lengths:**
  - `len`=0 → `m_tvalid` never rises, `busy` is high for one cycle, `done` is high in the cycle after `start`.
  - `len`=16 from `base_addr`=5 → 16 beats, wrapping once.
- **Ignored and hazard cases:**
  - A second `start` during READ with a different `base_addr` is ignored; the first command completes unchanged.
  - A write of 0xAB to entry 3 on the edge where entry 3 is loaded → the beat carries 0x33.
- **Reset mid-stream:** `rst_n` dropped during beat 2 of 8 → `m_tvalid`, `busy` and `done` go to 0 immediately. After release, `base_addr`=0, `len`=2 → beats 0x00, 0x11 with correct timing.
